// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: single-outstanding imem requests, IF/ID register with a
// one-entry holding buffer for decode stalls. Optional perf counters under IF_PERF_CNT_EN.
module if_fetch_stage #(
    parameter int unsigned       PC_W     = 32,
    parameter logic [PC_W-1:0]   RESET_PC = 32'h80000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            jump_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic            imem_req_valid,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            id_valid,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     id_inst,
    output logic            fetch_busy
`ifdef IF_PERF_CNT_EN
    ,
    output logic [63:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HOLD} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            buf_valid_q, buf_valid_d;
    logic [PC_W-1:0] buf_pc_q, buf_pc_d;
    logic [31:0]     buf_inst_q, buf_inst_d;
    logic            id_valid_q, id_valid_d;
    logic [PC_W-1:0] id_pc_q, id_pc_d;
    logic [31:0]     id_inst_q, id_inst_d;

    logic id_fire, slot_free, resp_deliver, resp_direct;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;

        id_fire      = id_valid_q & ~stall_i;
        slot_free    = ~id_valid_q | id_fire;
        resp_deliver = (state_q == S_WAIT) & imem_resp_valid & ~jump_i;
        // A response bypasses the buffer only when nothing older is waiting there.
        resp_direct  = slot_free & ~buf_valid_q;

        case (state_q)
            S_REQ: begin
                if (imem_req_ready) begin
                    if (jump_i) begin
                        state_d = S_DRAIN;
                    end else begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + PC_W'(4);
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (jump_i)           state_d = S_REQ;
                    else if (resp_direct) state_d = S_REQ;
                    else                  state_d = S_HOLD;
                end else if (jump_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_resp_valid) state_d = S_REQ;
            end
            S_HOLD: begin
                if (jump_i | slot_free) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        if (jump_i) begin
            fetch_pc_d  = redirect_pc_i;
            id_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
        end else begin
            if (slot_free) begin
                if (buf_valid_q) begin
                    id_valid_d  = 1'b1;
                    id_pc_d     = buf_pc_q;
                    id_inst_d   = buf_inst_q;
                    buf_valid_d = 1'b0;
                end else if (resp_deliver) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = req_pc_q;
                    id_inst_d  = imem_resp_data;
                end else begin
                    id_valid_d = 1'b0;
                end
            end
            if (resp_deliver & ~resp_direct) begin
                buf_valid_d = 1'b1;
                buf_pc_d    = req_pc_q;
                buf_inst_d  = imem_resp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= RESET_PC;
            buf_inst_q  <= NOP;
            id_valid_q  <= 1'b0;
            id_pc_q     <= RESET_PC;
            id_inst_q   <= NOP;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = fetch_pc_q;
    assign fetch_busy     = (state_q == S_WAIT) | (state_q == S_DRAIN);
    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_inst        = id_inst_q;

`ifdef IF_PERF_CNT_EN
    logic [63:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + (resp_deliver ? 64'd1 : 64'd0);
        perf_flush_d = perf_flush_q + (jump_i ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: the bench plays the instruction memory cycle by cycle.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        fetch_busy;

    int n_cmp = 0;
    int n_bad = 0;

    if_fetch_stage #(.PC_W(32), .RESET_PC(32'h80000000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .jump_i          (jump_i),
        .redirect_pc_i   (redirect_pc_i),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .fetch_busy      (fetch_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; jump_i = 1'b0; redirect_pc_i = '0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
        tick(); tick();
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_pc", id_pc, 32'h80000000);
        chk("rst_id_inst", id_inst, 32'h00000013);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rst_req_addr", imem_req_addr, 32'h80000000);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        $display("reset: id_valid=%0d id_pc=%h req_addr=%h", id_valid, id_pc, imem_req_addr);

        // 1: first fetch, response one cycle after accept
        rst = 1'b0;
        tick();
        chk("t1_wait_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t1_wait_busy", 32'(fetch_busy), 32'd1);
        chk("t1_id_not_yet", 32'(id_valid), 32'd0);
        imem_resp_valid = 1'b1; imem_resp_data = 32'h00000013;
        tick();
        chk("t1_id_valid", 32'(id_valid), 32'd1);
        chk("t1_id_pc", id_pc, 32'h80000000);
        chk("t1_id_inst", id_inst, 32'h00000013);
        chk("t1_req_addr", imem_req_addr, 32'h80000004);
        chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
        $display("t1: id_pc=%h id_inst=%h next_req=%h", id_pc, id_inst, imem_req_addr);

        // 2: stall holds IF/ID, response lands in the buffer
        imem_resp_valid = 1'b0; stall_i = 1'b1;
        tick();
        chk("t2_id_held_valid", 32'(id_valid), 32'd1);
        chk("t2_busy", 32'(fetch_busy), 32'd1);
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEADBEEF;
        tick();
        chk("t2_hold_id_pc", id_pc, 32'h80000000);
        chk("t2_hold_id_inst", id_inst, 32'h00000013);
        chk("t2_hold_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_hold_busy", 32'(fetch_busy), 32'd0);
        imem_resp_valid = 1'b0;
        tick();
        chk("t2_hold2_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_hold2_id_inst", id_inst, 32'h00000013);
        stall_i = 1'b0;
        tick();
        chk("t2_buf_id_valid", 32'(id_valid), 32'd1);
        chk("t2_buf_id_pc", id_pc, 32'h80000004);
        chk("t2_buf_id_inst", id_inst, 32'hDEADBEEF);
        chk("t2_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t2_req_addr", imem_req_addr, 32'h80000008);
        $display("t2: id_pc=%h id_inst=%h next_req=%h", id_pc, id_inst, imem_req_addr);

        // 3: redirect in WAIT, late response is drained
        tick();
        chk("t3_id_drained", 32'(id_valid), 32'd0);
        chk("t3_busy", 32'(fetch_busy), 32'd1);
        jump_i = 1'b1; redirect_pc_i = 32'h80001000;
        tick();
        jump_i = 1'b0;
        chk("t3_drain_busy", 32'(fetch_busy), 32'd1);
        chk("t3_drain_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h11111111;
        tick();
        imem_resp_valid = 1'b0;
        chk("t3_dropped_id_valid", 32'(id_valid), 32'd0);
        chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t3_req_addr", imem_req_addr, 32'h80001000);
        $display("t3: id_valid=%0d next_req=%h", id_valid, imem_req_addr);

        // 4: jump and response in the same cycle
        tick();
        chk("t4_busy", 32'(fetch_busy), 32'd1);
        jump_i = 1'b1; redirect_pc_i = 32'h80002000;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h22222222;
        tick();
        jump_i = 1'b0; imem_resp_valid = 1'b0;
        chk("t4_id_valid", 32'(id_valid), 32'd0);
        chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_req_addr", imem_req_addr, 32'h80002000);
        $display("t4: id_valid=%0d next_req=%h", id_valid, imem_req_addr);

        // 5: unaccepted request retargeted by a redirect
        imem_req_ready = 1'b0;
        tick();
        chk("t5_req_valid0", 32'(imem_req_valid), 32'd1);
        chk("t5_req_addr0", imem_req_addr, 32'h80002000);
        jump_i = 1'b1; redirect_pc_i = 32'h80000200;
        tick();
        jump_i = 1'b0;
        chk("t5_req_valid1", 32'(imem_req_valid), 32'd1);
        chk("t5_req_addr1", imem_req_addr, 32'h80000200);
        tick();
        chk("t5_req_addr2", imem_req_addr, 32'h80000200);
        imem_req_ready = 1'b1;
        tick();
        chk("t5_accepted_busy", 32'(fetch_busy), 32'd1);
        imem_resp_valid = 1'b1; imem_resp_data = 32'h33333333;
        tick();
        imem_resp_valid = 1'b0;
        chk("t5_id_pc", id_pc, 32'h80000200);
        chk("t5_id_inst", id_inst, 32'h33333333);
        $display("t5: id_pc=%h id_inst=%h", id_pc, id_inst);

        // 6: reset mid-transaction, stray response ignored
        tick();
        chk("t6_busy", 32'(fetch_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_busy", 32'(fetch_busy), 32'd0);
        chk("t6_rst_id_inst", id_inst, 32'h00000013);
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h44444444;
        tick();
        imem_resp_valid = 1'b0;
        chk("t6_stray_id_valid", 32'(id_valid), 32'd0);
        chk("t6_stray_id_inst", id_inst, 32'h00000013);
        chk("t6_req_addr", imem_req_addr, 32'h80000000);
        imem_req_ready = 1'b1;
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h55555555;
        tick();
        imem_resp_valid = 1'b0;
        chk("t6_id_pc", id_pc, 32'h80000000);
        chk("t6_id_inst", id_inst, 32'h55555555);
        $display("t6: id_pc=%h id_inst=%h", id_pc, id_inst);

        // 7: unaligned redirect near the top of the address space wraps on +4
        imem_req_ready = 1'b0; jump_i = 1'b1; redirect_pc_i = 32'hFFFFFFFE;
        tick();
        jump_i = 1'b0;
        chk("t7_req_addr", imem_req_addr, 32'hFFFFFFFE);
        imem_req_ready = 1'b1;
        tick();
        imem_resp_valid = 1'b1; imem_resp_data = 32'h66666666;
        tick();
        imem_resp_valid = 1'b0;
        chk("t7_id_pc", id_pc, 32'hFFFFFFFE);
        chk("t7_wrap_addr", imem_req_addr, 32'h00000002);
        $display("t7: id_pc=%h next_req=%h", id_pc, imem_req_addr);

        // 8: redirect flushes IF/ID even while decode stalls
        stall_i = 1'b1; jump_i = 1'b1; redirect_pc_i = 32'h80000100; imem_req_ready = 1'b0;
        tick();
        jump_i = 1'b0; stall_i = 1'b0;
        chk("t8_flush_id_valid", 32'(id_valid), 32'd0);
        chk("t8_req_addr", imem_req_addr, 32'h80000100);
        $display("t8: id_valid=%0d next_req=%h", id_valid, imem_req_addr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
